// File: rtl/muldiv_pkg.sv
// Shared RV32M definitions: opcode/funct fields and muldiv FSM encodings.
// Used by muldiv_decode and muldiv_unit.
package muldiv_pkg;

    localparam logic [6:0] OPCODE_ARITH  = 7'b0110011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] FUNCT3_MUL    = 3'b000;
    localparam logic [2:0] FUNCT3_MULH   = 3'b001;
    localparam logic [2:0] FUNCT3_MULHSU = 3'b010;
    localparam logic [2:0] FUNCT3_MULHU  = 3'b011;
    localparam logic [2:0] FUNCT3_DIV    = 3'b100;
    localparam logic [2:0] FUNCT3_DIVU   = 3'b101;
    localparam logic [2:0] FUNCT3_REM    = 3'b110;
    localparam logic [2:0] FUNCT3_REMU   = 3'b111;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_CALC = 2'd1,
        MD_FIX  = 2'd2
    } muldiv_state_e;

endpackage

// File: rtl/muldiv_decode.sv
// Combinational RV32M decode: classifies the instruction word and
// reports operand signedness and which half/part of the result is wanted.
module muldiv_decode
    import muldiv_pkg::*;
(
    input  logic [31:0] i_instr,
    output logic        o_is_muldiv,
    output logic        o_is_div,
    output logic        o_is_rem,
    output logic        o_want_high,
    output logic        o_a_signed,
    output logic        o_b_signed
);

    logic [2:0] w_funct3;
    logic       w_unused_fields;

    assign w_funct3        = i_instr[14:12];
    assign w_unused_fields = ^{i_instr[24:15], i_instr[11:7]};

    assign o_is_muldiv = (i_instr[6:0] == OPCODE_ARITH) &&
                         (i_instr[31:25] == FUNCT7_MULDIV);

    always_comb begin
        o_is_div    = 1'b0;
        o_is_rem    = 1'b0;
        o_want_high = 1'b0;
        o_a_signed  = 1'b0;
        o_b_signed  = 1'b0;
        unique case (w_funct3)
            FUNCT3_MUL: begin
                o_a_signed = 1'b1;
                o_b_signed = 1'b1;
            end
            FUNCT3_MULH: begin
                o_want_high = 1'b1;
                o_a_signed  = 1'b1;
                o_b_signed  = 1'b1;
            end
            FUNCT3_MULHSU: begin
                o_want_high = 1'b1;
                o_a_signed  = 1'b1;
            end
            FUNCT3_MULHU: begin
                o_want_high = 1'b1;
            end
            FUNCT3_DIV: begin
                o_is_div   = 1'b1;
                o_a_signed = 1'b1;
                o_b_signed = 1'b1;
            end
            FUNCT3_DIVU: begin
                o_is_div = 1'b1;
            end
            FUNCT3_REM: begin
                o_is_div   = 1'b1;
                o_is_rem   = 1'b1;
                o_a_signed = 1'b1;
                o_b_signed = 1'b1;
            end
            FUNCT3_REMU: begin
                o_is_div = 1'b1;
                o_is_rem = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit (shift-add / restoring, 1 bit per cycle).
// Define MULDIV_ZERO_SKIP_EN to bypass CALC for trivially-resolvable operands.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [31:0]     instruction,
    input  logic            start,
    input  logic            kill,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            is_muldiv,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    logic w_is_div;
    logic w_is_rem;
    logic w_want_high;
    logic w_a_signed;
    logic w_b_signed;

    muldiv_decode u_decode (
        .i_instr     (instruction),
        .o_is_muldiv (is_muldiv),
        .o_is_div    (w_is_div),
        .o_is_rem    (w_is_rem),
        .o_want_high (w_want_high),
        .o_a_signed  (w_a_signed),
        .o_b_signed  (w_b_signed)
    );

    muldiv_state_e   r_state;
    logic [CW-1:0]   r_count;
    logic [2:0]      r_funct3;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic            r_a_neg;
    logic            r_b_neg;
    logic            r_special;
    logic [XLEN-1:0] r_special_val;
    logic            r_done;
    logic [XLEN-1:0] r_result;

    logic            w_a_neg;
    logic            w_b_neg;
    logic [XLEN-1:0] w_a_mag;
    logic [XLEN-1:0] w_b_mag;
    logic            w_div_zero;
    logic            w_ovf;
    logic            w_skip;
    logic            w_special;
    logic [XLEN-1:0] w_special_val;
    logic            w_accept;

    assign w_a_neg = w_a_signed & rs1_data[XLEN-1];
    assign w_b_neg = w_b_signed & rs2_data[XLEN-1];
    assign w_a_mag = w_a_neg ? -rs1_data : rs1_data;
    assign w_b_mag = w_b_neg ? -rs2_data : rs2_data;

    assign w_div_zero = w_is_div && (rs2_data == '0);
    assign w_ovf      = w_is_div && w_a_signed &&
                        (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) &&
                        (rs2_data == '1);

`ifdef MULDIV_ZERO_SKIP_EN
    assign w_skip = w_is_div ? (w_a_mag < w_b_mag)
                             : ((rs1_data == '0) || (rs2_data == '0));
`else
    assign w_skip = 1'b0;
`endif

    assign w_special = w_div_zero | w_ovf | w_skip;
    assign w_accept  = start && is_muldiv && !kill;

    // Precomputed answers for ops that never need the iterative core
    always_comb begin
        w_special_val = '0;
        if (w_div_zero) begin
            w_special_val = w_is_rem ? rs1_data : '1;
        end else if (w_ovf) begin
            w_special_val = w_is_rem ? '0 : rs1_data;
        end else if (w_skip) begin
            w_special_val = (w_is_div && w_is_rem) ? rs1_data : '0;
        end
    end

    logic [XLEN:0]   w_mul_sum;
    logic [XLEN:0]   w_div_shift;
    logic [XLEN+1:0] w_div_diff;
    logic            w_div_ok;
    logic            w_unused_diff;
    logic [XLEN-1:0] w_nxt_hi;
    logic [XLEN-1:0] w_nxt_lo;

    assign w_mul_sum     = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
    assign w_div_shift   = {r_hi, r_lo[XLEN-1]};
    assign w_div_diff    = {1'b0, w_div_shift} - {2'b00, r_b};
    assign w_div_ok      = ~w_div_diff[XLEN+1];
    assign w_unused_diff = w_div_diff[XLEN];

    always_comb begin
        w_nxt_hi = w_mul_sum[XLEN:1];
        w_nxt_lo = {w_mul_sum[0], r_lo[XLEN-1:1]};
        if (r_funct3[2]) begin
            w_nxt_hi = w_div_ok ? w_div_diff[XLEN-1:0]
                                : w_div_shift[XLEN-1:0];
            w_nxt_lo = {r_lo[XLEN-2:0], w_div_ok};
        end
    end

    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_q_fix;
    logic [XLEN-1:0]   w_r_fix;
    logic [XLEN-1:0]   w_fix_val;
    logic              w_neg_res;

    assign w_neg_res  = r_a_neg ^ r_b_neg;
    assign w_prod_fix = w_neg_res ? -{r_hi, r_lo} : {r_hi, r_lo};
    assign w_q_fix    = w_neg_res ? -r_lo : r_lo;
    assign w_r_fix    = r_a_neg ? -r_hi : r_hi;

    always_comb begin
        w_fix_val = w_prod_fix[XLEN-1:0];
        if (r_special) begin
            w_fix_val = r_special_val;
        end else if (r_funct3[2]) begin
            w_fix_val = r_funct3[1] ? w_r_fix : w_q_fix;
        end else if (r_funct3[1:0] != 2'b00) begin
            w_fix_val = w_prod_fix[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= MD_IDLE;
            r_count       <= '0;
            r_funct3      <= '0;
            r_hi          <= '0;
            r_lo          <= '0;
            r_b           <= '0;
            r_a_neg       <= 1'b0;
            r_b_neg       <= 1'b0;
            r_special     <= 1'b0;
            r_special_val <= '0;
            r_done        <= 1'b0;
            r_result      <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                MD_IDLE: begin
                    if (w_accept) begin
                        r_funct3      <= instruction[14:12];
                        r_hi          <= '0;
                        r_lo          <= w_a_mag;
                        r_b           <= w_b_mag;
                        r_a_neg       <= w_a_neg;
                        r_b_neg       <= w_b_neg;
                        r_special     <= w_special;
                        r_special_val <= w_special_val;
                        r_count       <= w_special ? '0 : CW'(XLEN);
                        r_state       <= w_special ? MD_FIX : MD_CALC;
                    end
                end
                MD_CALC: begin
                    if (kill) begin
                        r_state <= MD_IDLE;
                    end else begin
                        r_hi    <= w_nxt_hi;
                        r_lo    <= w_nxt_lo;
                        r_count <= r_count - CW'(1);
                        if (r_count == CW'(1)) begin
                            r_state <= MD_FIX;
                        end
                    end
                end
                MD_FIX: begin
                    r_state <= MD_IDLE;
                    if (!kill) begin
                        r_result <= w_fix_val;
                        r_done   <= 1'b1;
                    end
                end
                default: r_state <= MD_IDLE;
            endcase
        end
    end

    assign busy   = (r_state != MD_IDLE);
    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit (XLEN=32).
// Honours MULDIV_ZERO_SKIP_EN for the expected zero-operand latency.
module tb_muldiv_unit;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        start;
    logic        kill;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        is_muldiv;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

`ifdef MULDIV_ZERO_SKIP_EN
    localparam int ZERO_LAT = 2;
`else
    localparam int ZERO_LAT = 34;
`endif

    muldiv_unit #(.XLEN(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .instruction (instruction),
        .start       (start),
        .kill        (kill),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
        .is_muldiv   (is_muldiv),
        .busy        (busy),
        .done        (done),
        .result      (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc(input logic [2:0] f3);
        return {7'b0000001, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues an op (possibly in the previous op's done cycle) and waits for done
    task automatic run_op(input string tag, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int lat);
        int n;
        instruction = enc(f3);
        rs1_data    = a;
        rs2_data    = b;
        start       = 1'b1;
        tick();
        start = 1'b0;
        n     = 1;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check({tag, " done"}, {31'd0, done}, 32'd1);
        check({tag, " lat"}, n, lat);
        check({tag, " result"}, result, exp);
    endtask

    initial begin
        int n;
        logic [31:0] prev;
        reset       = 1'b1;
        instruction = 32'h0;
        start       = 1'b0;
        kill        = 1'b0;
        rs1_data    = 32'h0;
        rs2_data    = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset result", result, 32'd0);

        instruction = enc(3'b000);
        #1;
        check("decode mul", {31'd0, is_muldiv}, 32'd1);
        instruction = 32'h002081B3;
        #1;
        check("decode add", {31'd0, is_muldiv}, 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("non-muldiv start", {31'd0, busy}, 32'd0);

        // MUL 7 * -3 with cycle-accurate busy/done trace
        instruction = enc(3'b000);
        rs1_data    = 32'd7;
        rs2_data    = 32'hFFFFFFFD;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 33; c++) begin
            check($sformatf("mul busy c%0d", c), {30'd0, busy, done}, 32'd2);
            tick();
        end
        check("mul c34 done", {31'd0, done}, 32'd1);
        check("mul c34 busy", {31'd0, busy}, 32'd0);
        check("mul result", result, 32'hFFFFFFEB);
        tick();
        check("mul done pulse", {31'd0, done}, 32'd0);

        run_op("mulh", 3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 34);
        run_op("mulhu", 3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 34);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 34);
        run_op("div", 3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 34);
        run_op("rem", 3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 34);
        run_op("divu", 3'b101, 32'd100, 32'd7, 32'd14, 34);
        run_op("remu b2b", 3'b111, 32'd100, 32'd7, 32'd2, 34);
        run_op("divu by0", 3'b101, 32'd5, 32'd0, 32'hFFFFFFFF, 2);
        run_op("rem by0", 3'b110, 32'd5, 32'd0, 32'd5, 2);
        run_op("div ovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 2);
        run_op("rem ovf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0, 2);
        run_op("mul zero", 3'b000, 32'd0, 32'd5, 32'd0, ZERO_LAT);
        tick();

        // start while busy must not restart or change the op
        instruction = enc(3'b000);
        rs1_data    = 32'd7;
        rs2_data    = 32'hFFFFFFFD;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 5; c++) tick();
        instruction = enc(3'b101);
        rs1_data    = 32'd100;
        rs2_data    = 32'd7;
        start       = 1'b1;
        tick();
        start = 1'b0;
        n     = 6;
        while (!done && n < 100) begin
            tick();
            n++;
        end
        check("busy start lat", n, 34);
        check("busy start result", result, 32'hFFFFFFEB);
        tick();
        prev = result;

        // kill at cycle 10 of a MUL
        instruction = enc(3'b000);
        rs1_data    = 32'd3;
        rs2_data    = 32'd3;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 10; c++) tick();
        check("kill pre busy", {31'd0, busy}, 32'd1);
        kill = 1'b1;
        tick();
        kill = 1'b0;
        check("kill busy", {31'd0, busy}, 32'd0);
        n = 0;
        for (int c = 0; c < 40; c++) begin
            if (done) n++;
            tick();
        end
        check("kill no done", n, 0);
        check("kill result held", result, prev);

        // kill together with start in IDLE: start loses
        start = 1'b1;
        kill  = 1'b1;
        tick();
        start = 1'b0;
        kill  = 1'b0;
        check("kill+start busy", {31'd0, busy}, 32'd0);

        // reset in the middle of an op
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 6; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset busy", {31'd0, busy}, 32'd0);
        check("midreset done", {31'd0, done}, 32'd0);
        check("midreset result", result, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative RV32M multiply/divide execution unit for the multi-cycle CPU. Sits beside the ALU in the EX stage.
- Decodes the instruction word itself, flagging MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU.
- Runs a start/busy/done handshake with the control FSM, so the FSM stalls in EX until done.
- Generalises ALU op decode to a parametrised-width, multi-cycle arithmetic mode the single-cycle ALU lacks.

Parameters:
- XLEN, 32, operand/result width in bits (>=8, power of 2); iteration counter width is clog2(XLEN)+1.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- instruction  in  32  current instruction word
- start  in  1  request to begin the op in instruction
- kill  in  1  synchronous abort (flush)
- rs1_data  in  XLEN  operand A
- rs2_data  in  XLEN  operand B
- is_muldiv  out  1  combinational: opcode==ARITHMETIC && funct7==0000001
- busy  out  1  operation in progress
- done  out  1  one-cycle pulse, result valid
- result  out  XLEN  final value; held until the next accepted start

Behaviour:
- Reset: state IDLE, busy=0, done=0, result=0, internal registers cleared. Reset mid-operation aborts the operation; outputs read 0 in the next cycle.
- FSM states are IDLE, CALC and FIX. busy=1 in CALC and FIX.
- Accept rule: in IDLE, start && is_muldiv && !kill latches funct3, both operands and their signs, and the computed special-case flags. start in CALC/FIX is ignored. start with is_muldiv=0 is ignored.
- Signed handling:
  - Operands are converted to magnitudes per funct3. MUL/MULH/DIV/REM: both signed. MULHSU: rs1 signed, rs2 unsigned. Others: unsigned.
  - The core is unsigned.
  - FIX negates the result: product if the signs differ; quotient if the signs differ; remainder takes the sign of the dividend.
- Multiply: shift-add, 1 bit/cycle, 2*XLEN product. MUL returns the low XLEN bits; the MULH variants return the high XLEN bits.
- Divide: restoring, 1 quotient bit/cycle. DIV/DIVU return the quotient; REM/REMU return the remainder.
- Normal path timing:
  - start sampled in cycle c, then XLEN CALC cycles (c+1..c+XLEN).
  - FIX in cycle c+XLEN+1.
  - done=1 and result valid in cycle c+XLEN+2, with state back in IDLE.
  - Latency is XLEN+2 cycles.
- Special cases bypass CALC, going IDLE→FIX, so done arrives at c+2:
  - Divide by zero: DIV/DIVU give all-ones; REM/REMU give rs1.
  - Signed overflow (rs1 = -2^(XLEN-1), rs2 = -1): DIV gives rs1, REM gives 0.
- done is high exactly one cycle. A start in the done cycle is accepted (back-to-back).
- kill:
  - In CALC/FIX, goes to IDLE next cycle: busy=0, no done, result unchanged.
  - kill with start in the same cycle: kill wins and start is ignored.
  - kill in IDLE has no effect.
- The counter runs down from XLEN to 0 with no wrap; CALC exits on the cycle the count reaches 1.

Optional Feature:
- Macro MULDIV_ZERO_SKIP_EN.
- Defined: FIX is entered directly, with latency 2, when the op is a multiply with either operand zero, or a divide/rem whose unsigned dividend magnitude is less than the divisor magnitude. Quotient is 0 and remainder is the dividend, sign-fixed as usual.
- Undefined: only the divide-by-zero and overflow cases bypass; all other ops take XLEN+2 cycles.
- Results are identical in both builds.

Decomposition:
- Shared header (alongside the opcode/funct definitions):
  - FUNCT7_MULDIV=7'b0000001
  - FUNCT3_MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU
  - muldiv state encodings IDLE/CALC/FIX
- One sub-module, muldiv_decode: combinational instruction→{is_muldiv, is_div, is_rem, want_high, a_signed, b_signed}.

Test Plan:
- MUL rs1=7, rs2=0xFFFFFFFD (-3), start at cycle 0 → busy cycles 1–33, done=1 at cycle 34, result=0xFFFFFFEB.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14; REMU → 2. A second start issued in the done cycle is accepted.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM same → 0. done at start+2 for each.
- During a MUL:
  - kill at cycle 10 → busy=0 at cycle 11, done never pulses, result keeps its previous value.
  - start pulsed while busy is ignored.
  - reset mid-op → busy=0, done=0, result=0 next cycle.
- MUL 0×5: with MULDIV_ZERO_SKIP_EN → result 0, done at start+2. Without → result 0, done at start+34.
